i2s2_slave_tx: RTL
==================

// Module: i2s2_slave_tx
// PURPOSE
//  I2S slave-side serialiser: the codec-facing counterpart of the I2S2 master transceiver. SCLK and
//  LRCK are driven externally by the master; this block drives SDOUT with 24-bit stereo samples
//  in standard I2S format (MSB first, one-SCLK delay after LRCK edge, LRCK low = left).
//  Sits between a sample source (FIR output or test generator) and the serial line. Runs entirely
//  on MCLK and oversamples SCLK/LRCK.
// PARAMETERS
//  DATA_WIDTH   24  bits per channel word, MSB first
//  SYNC_STAGES  2   flops in SCLK/LRCK synchronisers (>=2)
// PORTS
//  MCLK        in   1           system clock (22.579 MHz); SCLK half-period must be >= 4 MCLK cycles
//  RST_N       in   1           asynchronous, active-low reset
//  SCLK        in   1           serial bit clock from master (async to MCLK)
//  LRCK        in   1           word select from master: 0 = left, 1 = right
//  LEFT_TX     in   DATA_WIDTH  left sample, two's complement
//  RIGHT_TX    in   DATA_WIDTH  right sample, two's complement
//  TX_VALID    in   1           sample pair on LEFT_TX/RIGHT_TX is valid
//  TX_READY    out  1           holding buffer empty; pair accepted when TX_VALID & TX_READY
//  SDOUT       out  1           serial data, changes only after detected SCLK falling edges
//  FRAME_START out  1           1-MCLK pulse when a left word begins shifting
//  UNDERRUN    out  1           1-MCLK pulse when a frame starts with no new pair buffered
// BEHAVIOUR
//  - Reset: SDOUT=0, TX_READY=1, FRAME_START=0, UNDERRUN=0; holding/active regs=0; not primed.
//  - SCLK/LRCK pass through SYNC_STAGES flops; SCLK rise/fall detected as 1-MCLK strobes.
//  - On SCLK rise strobe: sample LRCK into lr_q. First sample after reset only primes lr_prev
//    (no load). Thereafter lr_q != lr_prev sets load_pending with channel = lr_q.
//  - On SCLK fall strobe: if load_pending, SDOUT <= word[DATA_WIDTH-1], shift reg <= rest,
//    bit_cnt <= DATA_WIDTH-1, clear load_pending; else if bit_cnt>0 shift next bit, decrement;
//    else SDOUT <= 0 (pad bits until next LRCK change).
//  - Latency: SDOUT valid SYNC_STAGES+1 MCLK after the pin-level SCLK falling edge.
//  - Word source: left load uses active_left, right load uses active_right.
//  - Frame transfer on left load cycle: if holding full -> active <= holding, holding empty,
//    FRAME_START=1; else active unchanged (previous pair repeats), FRAME_START=1, UNDERRUN=1.
//  - Accept: TX_VALID & TX_READY writes holding and sets full; TX_READY = !full (registered).
//    Transfer is evaluated on pre-cycle state: accept in same cycle as an empty-buffer transfer
//    -> UNDERRUN, new pair stays in holding for next frame.
//  - Right pair always belongs to the same transfer as its left word (no mid-frame tearing).
//  - LRCK change before DATA_WIDTH bits sent: current word abandoned, new channel loads.
//  - Reset mid-word: SDOUT 0 immediately; output resumes one bit after the next real LRCK edge.
// STRUCTURE
//  - Package i2s2_pkg: CH_LEFT=1'b0, CH_RIGHT=1'b1, I2S_DATA_WIDTH=24 default.
//  - Sub-module i2s2_edge_sync: N-stage synchroniser + rise/fall strobes; used for SCLK (edges)
//    and LRCK (level only). Shift/handshake logic stays in this module.
// TESTING
//  - Master model SCLK=MCLK/8, LRCK=SCLK/64; push L=24'hA5A5A5, R=24'h5A5A5A -> bits 2..25 after
//    LRCK fall decode 24'hA5A5A5, after rise 24'h5A5A5A; pad bits 0; FRAME_START once per frame.
//  - No TX_VALID after first pair -> second frame repeats A5A5A5/5A5A5A, UNDERRUN pulses once.
//  - TX_VALID held high with 3 distinct pairs -> TX_READY drops after accept, reasserts on each
//    FRAME_START; decoded frames show pairs in order, none lost or duplicated.
//  - Push pair exactly on FRAME_START cycle with empty buffer -> UNDERRUN=1, pair appears next frame.
//  - Assert RST_N low mid-left-word -> SDOUT=0 at once, TX_READY=1; release mid-right slot ->
//    SDOUT stays 0 until bit after next LRCK edge, then correct word.
//  - Truncated slot (LRCK toggles after 16 SCLKs) -> next channel MSB on following SCLK fall.

Source files
------------

// File: rtl/i2s2_pkg.sv
// i2s2_pkg
//   Shared constants for the I2S2 slave-side serialiser.
//   CH_LEFT / CH_RIGHT : channel encoding carried by LRCK (0 = left, 1 = right)
//   I2S_DATA_WIDTH     : default bits per channel word
package i2s2_pkg;

    localparam logic CH_LEFT        = 1'b0;
    localparam logic CH_RIGHT       = 1'b1;
    localparam int   I2S_DATA_WIDTH = 24;

endpackage

// File: rtl/i2s2_edge_sync.sv
// i2s2_edge_sync
//   Multi-flop synchroniser for a signal that is asynchronous to clk, plus
//   single-cycle rise/fall strobes derived from the synchronised level.
//   Ports:
//     clk    in  : sampling clock
//     rst_n  in  : asynchronous active-low reset (chain and history clear to 0)
//     d      in  : asynchronous input
//     level  out : synchronised level (STAGES flops after d)
//     rise   out : 1-cycle strobe on a synchronised 0->1 transition
//     fall   out : 1-cycle strobe on a synchronised 1->0 transition
module i2s2_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  =  sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/i2s2_slave_tx.sv
// i2s2_slave_tx
//   I2S slave serialiser running on MCLK. SCLK/LRCK come from an external
//   master and are oversampled; SDOUT carries 24-bit stereo words in standard
//   I2S framing (MSB first, one SCLK after the LRCK edge, LRCK low = left).
//   Ports:
//     MCLK, RST_N          : system clock, asynchronous active-low reset
//     SCLK, LRCK           : bit clock and word select from the master
//     LEFT_TX, RIGHT_TX    : sample pair to send
//     TX_VALID / TX_READY  : sample-pair handshake into the holding buffer
//     SDOUT                : serial data, updated after detected SCLK falls
//     FRAME_START          : 1-MCLK pulse when a left word starts shifting
//     UNDERRUN             : 1-MCLK pulse when that frame had no new pair
//
//   Handshake: a pair is taken on every MCLK edge where TX_VALID and
//   TX_READY are both high; TX_READY is high exactly while the holding
//   buffer is empty and comes straight from a flop. The source must hold
//   LEFT_TX/RIGHT_TX stable while TX_VALID is high and not yet accepted.
module i2s2_slave_tx
    import i2s2_pkg::*;
#(
    parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  MCLK,
    input  logic                  RST_N,
    input  logic                  SCLK,
    input  logic                  LRCK,
    input  logic [DATA_WIDTH-1:0] LEFT_TX,
    input  logic [DATA_WIDTH-1:0] RIGHT_TX,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic                  SDOUT,
    output logic                  FRAME_START,
    output logic                  UNDERRUN
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic sclk_rise;
    logic sclk_fall;
    logic sclk_level_unused;
    logic lrck_s;
    logic lrck_rise_unused;
    logic lrck_fall_unused;

    i2s2_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (MCLK),
        .rst_n (RST_N),
        .d     (SCLK),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Same depth as the SCLK chain so LRCK keeps its phase relative to SCLK.
    i2s2_edge_sync #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk   (MCLK),
        .rst_n (RST_N),
        .d     (LRCK),
        .level (lrck_s),
        .rise  (lrck_rise_unused),
        .fall  (lrck_fall_unused)
    );

    logic                  primed_q,       primed_d;
    logic                  lr_prev_q,      lr_prev_d;
    logic                  load_pending_q, load_pending_d;
    logic                  load_ch_q,      load_ch_d;
    logic [DATA_WIDTH-1:0] shift_q,        shift_d;
    logic [CNT_W-1:0]      bit_cnt_q,      bit_cnt_d;
    logic                  sdout_q,        sdout_d;
    logic [DATA_WIDTH-1:0] hold_l_q,       hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q,       hold_r_d;
    logic                  full_q,         full_d;
    logic [DATA_WIDTH-1:0] act_l_q,        act_l_d;
    logic [DATA_WIDTH-1:0] act_r_q,        act_r_d;

    logic                  left_load;
    logic                  accept;
    logic [DATA_WIDTH-1:0] load_word;

    assign left_load = sclk_fall & load_pending_q & (load_ch_q == CH_LEFT);
    assign accept    = TX_VALID & ~full_q;

    // The left word is taken from whatever becomes active on this very cycle,
    // so a fresh pair starts with its own left word and the right word later
    // reads the same pair from the active registers.
    assign load_word = (load_ch_q == CH_LEFT) ? (full_q ? hold_l_q : act_l_q)
                                              : act_r_q;

    always_comb begin
        primed_d       = primed_q;
        lr_prev_d      = lr_prev_q;
        load_pending_d = load_pending_q;
        load_ch_d      = load_ch_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        sdout_d        = sdout_q;
        hold_l_d       = hold_l_q;
        hold_r_d       = hold_r_q;
        full_d         = full_q;
        act_l_d        = act_l_q;
        act_r_d        = act_r_q;

        // LRCK is judged on SCLK rises; the first rise only learns the level
        // so a reset never turns into a spurious word start.
        if (sclk_rise) begin
            if (!primed_q) begin
                primed_d  = 1'b1;
                lr_prev_d = lrck_s;
            end else if (lrck_s != lr_prev_q) begin
                lr_prev_d      = lrck_s;
                load_pending_d = 1'b1;
                load_ch_d      = lrck_s;
            end
        end

        // A pending load always wins, which abandons a word cut short by LRCK.
        if (sclk_fall) begin
            if (load_pending_q) begin
                sdout_d        = load_word[DATA_WIDTH-1];
                shift_d        = {load_word[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_d      = CNT_W'(DATA_WIDTH - 1);
                load_pending_d = 1'b0;
            end else if (bit_cnt_q != '0) begin
                sdout_d   = shift_q[DATA_WIDTH-1];
                shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 1'b1;
            end else begin
                sdout_d = 1'b0;
            end
        end

        if (left_load && full_q) begin
            act_l_d = hold_l_q;
            act_r_d = hold_r_q;
            full_d  = 1'b0;
        end

        // Acceptance looks at the pre-cycle full flag; a pair arriving on an
        // empty-buffer frame start waits in holding for the next frame.
        if (accept) begin
            hold_l_d = LEFT_TX;
            hold_r_d = RIGHT_TX;
            full_d   = 1'b1;
        end
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            primed_q       <= 1'b0;
            lr_prev_q      <= 1'b0;
            load_pending_q <= 1'b0;
            load_ch_q      <= 1'b0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            sdout_q        <= 1'b0;
            hold_l_q       <= '0;
            hold_r_q       <= '0;
            full_q         <= 1'b0;
            act_l_q        <= '0;
            act_r_q        <= '0;
        end else begin
            primed_q       <= primed_d;
            lr_prev_q      <= lr_prev_d;
            load_pending_q <= load_pending_d;
            load_ch_q      <= load_ch_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            sdout_q        <= sdout_d;
            hold_l_q       <= hold_l_d;
            hold_r_q       <= hold_r_d;
            full_q         <= full_d;
            act_l_q        <= act_l_d;
            act_r_q        <= act_r_d;
        end
    end

    assign SDOUT       = sdout_q;
    assign TX_READY    = ~full_q;
    assign FRAME_START = left_load;
    assign UNDERRUN    = left_load & ~full_q;

endmodule
